// File: rtl/dbus_pkg.sv
// Shared decode constants, region type and byte-lane merge for the data-bus responder.
// Latency: n/a (package only).
// Backpressure: n/a.
package dbus_pkg;

  // MMIO register byte offsets inside the 16-byte window
  localparam logic [3:0] OFF_STATUS  = 4'h0;
  localparam logic [3:0] OFF_CYCLE   = 4'h4;
  localparam logic [3:0] OFF_CONSOLE = 4'h8;
  localparam logic [3:0] OFF_CSTAT   = 4'hC;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  // Replace only the byte lanes whose strobe is set
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Console TX byte FIFO with sticky overflow flag.
// Latency: pushed byte appears on dout one cycle after the push edge (no bypass).
// Backpressure: push when full drops the byte and sets overflow unless a pop happens the same cycle.
module console_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  input  logic             ovf_clr
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign count    = cnt_q;
  assign overflow = ovf_q;
  // Head is forced to zero when empty so the output is clean out of reset
  assign dout     = empty ? '0 : mem_q[rd_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer, count and overflow next-state
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    ovf_d = ovf_q;
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push) wr_d = wr_q + AW'(1);
    if (ovf_clr) ovf_d = 1'b0;
    if (push && !do_push) ovf_d = 1'b1;
  end

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Byte storage: reset only blocks a coinciding push, contents are not cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else if (do_push) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus slave for the single-cycle core: word RAM plus STATUS/CYCLE/CONSOLE/CSTAT MMIO.
// Latency: loads combinational; stores commit at the rising edge, visible next cycle.
// Backpressure: none on the core bus; console drains over tx_valid/tx_ready, overflow drops bytes.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] PASS_CODE  = 32'd25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        sim_done,
  output logic        sim_pass,
  output logic        bus_err
);

  localparam int IDXW = $clog2(RAM_WORDS);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  region_e         region;
  logic            misaligned, wr_ok, ram_we, mmio_we;
  logic [3:0]      off;
  logic [IDXW-1:0] ram_idx;
  logic [31:0]     ram_q [RAM_WORDS];
  logic            done_q, done_d, pass_q, pass_d, err_q, err_d;
  logic [31:0]     cycle_q;
  logic            fifo_push, fifo_empty, fifo_full, fifo_ovf, ovf_clr;
  logic [CW-1:0]   fifo_cnt;
  logic [7:0]      cnt8;

  // Address decode on the word address; byte offset only matters for store alignment
  always_comb begin
    region = REG_NONE;
    if (addr[31:2] < 30'(RAM_WORDS))           region = REG_RAM;
    else if (addr[31:4] == MMIO_BASE[31:4])    region = REG_MMIO;
  end

  assign off        = {addr[3:2], 2'b00};
  assign ram_idx    = addr[IDXW+1:2];
  assign misaligned = mem_we & (addr[1:0] != 2'b00);
  assign wr_ok      = mem_we & ~misaligned & (region != REG_NONE);
  assign ram_we     = wr_ok & (region == REG_RAM);
  assign mmio_we    = wr_ok & (region == REG_MMIO);
  assign fifo_push  = mmio_we & (off == OFF_CONSOLE) & wstrb[0];
  assign ovf_clr    = mmio_we & (off == OFF_CSTAT);
  assign cnt8       = 8'(fifo_cnt);

  // RAM write port: reset discards a coinciding store but never clears contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else if (ram_we) begin
      ram_q[ram_idx] <= lane_merge(ram_q[ram_idx], wdata, wstrb);
    end
  end

  // STATUS latches once; bad stores raise the sticky error
  always_comb begin
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    if (mmio_we && off == OFF_STATUS && !done_q) begin
      done_d = 1'b1;
      pass_d = (wdata == PASS_CODE);
    end
    if (mem_we && !wr_ok) err_d = 1'b1;
  end

  // Status flags and free-running cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // Combinational load data; reads see pre-edge contents during a store
  always_comb begin
    rdata = '0;
    if (region == REG_RAM) begin
      rdata = ram_q[ram_idx];
    end else if (region == REG_MMIO) begin
      case (off)
        OFF_STATUS: rdata = {30'b0, pass_q, done_q};
        OFF_CYCLE:  rdata = cycle_q;
        OFF_CSTAT:  rdata = {23'b0, fifo_ovf, cnt8};
        default:    rdata = '0;
      endcase
    end
  end

  console_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .din      (wdata[7:0]),
    .pop      (tx_ready),
    .dout     (tx_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_cnt),
    .overflow (fifo_ovf),
    .ovf_clr  (ovf_clr)
  );

  assign tx_valid = ~fifo_empty;
  assign sim_done = done_q;
  assign sim_pass = pass_q;
  assign bus_err  = err_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: RAM, STATUS, CYCLE, console FIFO, errors, async reset.
// Latency: inputs driven at negedge, outputs sampled away from the rising edge.
// Backpressure: tx_ready toggled to exercise full/empty push-pop corners.
module tb_dbus_responder;

  localparam logic [31:0] MB = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        sim_done, sim_pass, bus_err;

  int n_cmp = 0;
  int n_err = 0;

  dbus_responder dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .sim_done(sim_done), .sim_pass(sim_pass), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    addr = a; wdata = d; wstrb = s; mem_we = 1'b1;
    @(posedge clk);
    #1 mem_we = 1'b0; addr = '0; wstrb = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1 d = rdata;
    addr = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (sim_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", sim_done); end
    n_cmp++; if (sim_pass !== 1'b0) begin n_err++; $display("FAIL reset_pass got %b want 0", sim_pass); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", bus_err); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_txv got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_txd got %h want 00", tx_data); end
  endtask

  task automatic test_cycle();
    @(negedge clk);
    reset = 1'b0;
    addr = MB + 32'h4;
    repeat (10) @(posedge clk);
    #2;
    n_cmp++; if (rdata !== 32'd10) begin n_err++; $display("FAIL cycle_10 got %0d want 10", rdata); end
    addr = '0;
  endtask

  task automatic test_ram_write();
    logic [31:0] d;
    wr(32'h64, 32'd25, 4'hF);
    rd(32'h64, d);
    n_cmp++; if (d !== 32'h0000_0019) begin n_err++; $display("FAIL ram_rd got %h want 00000019", d); end
    n_cmp++; if (sim_done !== 1'b0) begin n_err++; $display("FAIL ram_done got %b want 0", sim_done); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL ram_err got %b want 0", bus_err); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    wr(32'h10, 32'h1122_3344, 4'hF);
    @(negedge clk);
    addr = 32'h10; wdata = 32'h00AB_0000; wstrb = 4'b0100; mem_we = 1'b1;
    #1;
    n_cmp++; if (rdata !== 32'h1122_3344) begin n_err++; $display("FAIL rd_old got %h want 11223344", rdata); end
    @(posedge clk);
    #1 mem_we = 1'b0; wstrb = '0;
    rd(32'h10, d);
    n_cmp++; if (d !== 32'h11AB_3344) begin n_err++; $display("FAIL lane2 got %h want 11ab3344", d); end
    wr(32'h10, 32'hAA00_00BB, 4'b1001);
    rd(32'h10, d);
    n_cmp++; if (d !== 32'hAAAB_33BB) begin n_err++; $display("FAIL lane03 got %h want aaab33bb", d); end
    rd(32'h2000, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_rd got %h want 0", d); end
  endtask

  task automatic test_status();
    logic [31:0] d;
    wr(MB, 32'd25, 4'hF);
    @(negedge clk);
    n_cmp++; if (sim_done !== 1'b1) begin n_err++; $display("FAIL st_done got %b want 1", sim_done); end
    n_cmp++; if (sim_pass !== 1'b1) begin n_err++; $display("FAIL st_pass got %b want 1", sim_pass); end
    rd(MB, d);
    n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL st_rd got %h want 3", d); end
    wr(MB, 32'd7, 4'hF);
    @(negedge clk);
    n_cmp++; if ({sim_done, sim_pass} !== 2'b11) begin n_err++; $display("FAIL st_sticky got %b want 11", {sim_done, sim_pass}); end
    pulse_reset();
    wr(MB, 32'd7, 4'hF);
    wr(MB, 32'd25, 4'hF);
    @(negedge clk);
    n_cmp++; if ({sim_done, sim_pass} !== 2'b10) begin n_err++; $display("FAIL st_fail got %b want 10", {sim_done, sim_pass}); end
    rd(MB, d);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL st_rd2 got %h want 1", d); end
  endtask

  task automatic test_console();
    logic [31:0] d;
    tx_ready = 1'b0;
    wr(MB + 32'h8, 32'h0000_0041, 4'h1);
    @(negedge clk);
    n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h41}) begin n_err++; $display("FAIL con_first got %b/%h want 1/41", tx_valid, tx_data); end
    for (int i = 1; i < 5; i++) wr(MB + 32'h8, 32'h41 + i, 4'h1);
    rd(MB + 32'hC, d);
    n_cmp++; if (d !== 32'h0000_0104) begin n_err++; $display("FAIL cstat_ovf got %h want 00000104", d); end
    @(negedge clk);
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'(8'h41 + i)}) begin n_err++; $display("FAIL drain%0d got %b/%h want 1/%h", i, tx_valid, tx_data, 8'h41 + i); end
      @(negedge clk); #1;
    end
    n_cmp++; if ({tx_valid, tx_data} !== 9'h0) begin n_err++; $display("FAIL drain_end got %b/%h want 0/00", tx_valid, tx_data); end
    tx_ready = 1'b0;
    rd(MB + 32'hC, d);
    n_cmp++; if (d !== 32'h0000_0100) begin n_err++; $display("FAIL cstat_empty got %h want 00000100", d); end
    wr(MB + 32'hC, 32'h0, 4'hF);
    rd(MB + 32'hC, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL cstat_clr got %h want 0", d); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) wr(MB + 32'h8, 32'h50 + i, 4'h1);
    @(negedge clk);
    addr = MB + 32'h8; wdata = 32'h54; wstrb = 4'h1; mem_we = 1'b1; tx_ready = 1'b1;
    @(posedge clk);
    #1 mem_we = 1'b0; tx_ready = 1'b0; addr = '0; wstrb = '0;
    rd(MB + 32'hC, d);
    n_cmp++; if (d !== 32'h0000_0004) begin n_err++; $display("FAIL full_pp_cstat got %h want 00000004", d); end
    n_cmp++; if (tx_data !== 8'h51) begin n_err++; $display("FAIL full_pp_head got %h want 51", tx_data); end
    @(negedge clk);
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'(8'h51 + i)}) begin n_err++; $display("FAIL full_drain%0d got %b/%h want 1/%h", i, tx_valid, tx_data, 8'h51 + i); end
      @(negedge clk); #1;
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL full_drain_end got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_empty_push_pop();
    @(negedge clk);
    tx_ready = 1'b1;
    addr = MB + 32'h8; wdata = 32'h60; wstrb = 4'h1; mem_we = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL ep_bypass got %b want 0", tx_valid); end
    @(posedge clk);
    #1 mem_we = 1'b0; addr = '0; wstrb = '0;
    @(negedge clk);
    n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h60}) begin n_err++; $display("FAIL ep_push got %b/%h want 1/60", tx_valid, tx_data); end
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL ep_pop got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_bus_err();
    logic [31:0] d;
    pulse_reset();
    wr(MB + 32'h4, 32'h1234, 4'hF);
    @(negedge clk);
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL cyc_wr_err got %b want 0", bus_err); end
    wr(32'h64, 32'hCAFE_F00D, 4'hF);
    wr(32'h66, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL misalign_err got %b want 1", bus_err); end
    rd(32'h64, d);
    n_cmp++; if (d !== 32'hCAFE_F00D) begin n_err++; $display("FAIL misalign_ram got %h want cafef00d", d); end
    pulse_reset();
    wr(32'h2000, 32'h5, 4'hF);
    @(negedge clk);
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL unmapped_err got %b want 1", bus_err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    pulse_reset();
    wr(32'h20, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 3; i++) wr(MB + 32'h8, 32'h70 + i, 4'h1);
    wr(MB, 32'd25, 4'hF);
    wr(32'h2000, 32'h0, 4'hF);
    @(negedge clk);
    n_cmp++; if ({tx_valid, sim_done, sim_pass, bus_err} !== 4'b1111) begin n_err++; $display("FAIL pre_rst got %b want 1111", {tx_valid, sim_done, sim_pass, bus_err}); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({tx_valid, sim_done, sim_pass, bus_err} !== 4'b0000) begin n_err++; $display("FAIL async_rst got %b want 0000", {tx_valid, sim_done, sim_pass, bus_err}); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL async_rst_txd got %h want 00", tx_data); end
    @(negedge clk);
    addr = 32'h20; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; mem_we = 1'b1;
    @(posedge clk);
    #1 mem_we = 1'b0; addr = '0; wstrb = '0;
    @(negedge clk) reset = 1'b0;
    rd(32'h20, d);
    n_cmp++; if (d !== 32'h1234_5678) begin n_err++; $display("FAIL rst_wr_drop got %h want 12345678", d); end
    rd(MB + 32'hC, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_cstat got %h want 0", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cycle();
    test_ram_write();
    test_byte_lanes();
    test_status();
    test_console();
    test_full_push_pop();
    test_empty_push_pop();
    test_bus_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
